// File: rtl/pulse_sequencer_pkg.sv
// pulse_sequencer_pkg: constants shared by the pulse sequencer and the pulse-width generator
package pulse_sequencer_pkg;
    localparam int PULSE_WIDTH  = 4;
    localparam int WD_LIMIT_DEF = 24;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;
endpackage

// File: rtl/pulse_seq_fifo.sv
// pulse_seq_fifo: circular DEPTHxWIDTH queue; a write while full is dropped and flagged even if a pop coincides
module pulse_seq_fifo
    import pulse_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PULSE_WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign ovf     = push && full;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: issues queued pulse widths to the generator, with done watchdog, idle gap and status counters
module pulse_sequencer
    import pulse_sequencer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = PULSE_WIDTH,
    parameter int WD_LIMIT = WD_LIMIT_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             run,
    input  logic [3:0]       gap,
    input  logic             clr_err,
    input  logic             gen_done,
    output logic             gen_start,
    output logic             gen_enable,
    output logic [WIDTH-1:0] gen_width,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             busy,
    output logic [7:0]       pulse_cnt,
    output logic             overflow,
    output logic             timeout
);
    localparam int WDW = $clog2(WD_LIMIT + 1);
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WDW-1:0]   wd;
    logic [3:0]       gap_cnt;
    logic [WIDTH-1:0] head;
    logic             ovf_set;
    logic             issue_go;
    logic             done_ok;
    logic             wd_exp;
    pulse_seq_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (done_ok || wd_exp),
        .din   (wr_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (ovf_set)
    );
    assign busy     = state != S_IDLE;
    assign issue_go = state == S_IDLE && run && !fifo_empty;
    assign done_ok  = state == S_WAIT && gen_done;
    assign wd_exp   = state == S_WAIT && !gen_done && wd == WDW'(WD_LIMIT - 1);
    always_comb
        next_state = state == S_IDLE  ? (issue_go ? S_ISSUE : S_IDLE) :
                     state == S_ISSUE ? S_WAIT :
                     state == S_WAIT  ? (done_ok ? (gap != 4'd0 ? S_GAP : S_IDLE) : wd_exp ? S_IDLE : S_WAIT) :
                                        (gap_cnt == 4'd1 ? S_IDLE : S_GAP);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= S_IDLE;
            gen_start  <= 1'b0;
            gen_enable <= 1'b0;
            gen_width  <= '0;
            wd         <= '0;
            gap_cnt    <= '0;
            pulse_cnt  <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= next_state;
            gen_start  <= issue_go;
            gen_enable <= issue_go;
            gen_width  <= issue_go ? head : gen_width;
            wd         <= state == S_ISSUE ? '0 : state == S_WAIT ? wd + WDW'(1) : wd;
            gap_cnt    <= done_ok ? gap : state == S_GAP ? gap_cnt - 4'd1 : gap_cnt;
            pulse_cnt  <= done_ok ? pulse_cnt + 8'd1 : pulse_cnt;
            overflow   <= ovf_set || (overflow && !clr_err);
            timeout    <= wd_exp || (timeout && !clr_err);
        end
endmodule
